tron_round_ctrl: RTL and testbench
==================================

// Module: tron_round_ctrl
// PURPOSE
//  Match sequencer for the Tron arena: generates Game_State that the arena datapath obeys
//  (001 = hold bikes at spawn, 010 = advance bikes, all other codes freeze them).
//  Walks idle -> spawn countdown -> play -> round over -> match over; keeps per-player scores.
//  Sits between keyboard/collision logic and the arena and sprite blocks; sole Game_State driver.
// PARAMETERS
//  COUNTDOWN_FRAMES  180    frames held in SPAWN before PLAY (3 s at 60 Hz); 1..255
//  OVER_FRAMES       120    frames held in ROUND_OVER before next round/match end; 1..255
//  WIN_SCORE         3      round wins needed to take the match; 1..7
//  START_KEY         8'h2C  keycode that starts/restarts a match (space)
//  PAUSE_KEY         8'h13  keycode that toggles pause (P); used only with TRON_PAUSE_EN
// PORTS
//  Clk         in   1  50 MHz system clock
//  Reset_n     in   1  asynchronous, active-low reset
//  frame_clk   in   1  ~60 Hz frame strobe from VGA (asynchronous to Clk)
//  keycode     in   8  current USB keycode, 8'h00 = none
//  Blue_crash  in   1  level: blue bike hit wall/trail this frame
//  Red_crash   in   1  level: red bike hit wall/trail this frame
//  Game_State  out  3  000 IDLE, 001 SPAWN, 010 PLAY, 011 ROUND_OVER, 100 MATCH_OVER, 110 PAUSE
//  Countdown   out  8  frames remaining in SPAWN/ROUND_OVER, else 0
//  Blue_score  out  3  blue round wins, 0..WIN_SCORE
//  Red_score   out  3  red round wins, 0..WIN_SCORE
//  Winner      out  2  last result: 00 none, 01 blue, 10 red, 11 draw
// BEHAVIOUR
//  Reset (async, Reset_n=0): Game_State=000, Countdown=0, scores=0, Winner=00, sync flops cleared.
//  All outputs registered; decisions on cycle n appear on outputs at n+1.
//  frame_clk: 2-flop synchroniser + edge register; one-Clk frame_tick per rising edge.
//  Key press = keycode==KEY this Clk and !=KEY previous Clk (held key = one press).
//  IDLE: START press -> SPAWN; scores=0, Winner=00, Countdown=COUNTDOWN_FRAMES.
//  SPAWN: each frame_tick Countdown-=1; tick while Countdown==1 -> PLAY, Countdown=0.
//  PLAY: crash inputs sampled every Clk:
//   both high -> Winner=11, no score change; Blue_crash only -> Red_score+1, Winner=10;
//   Red_crash only -> Blue_score+1, Winner=01; any crash -> ROUND_OVER, Countdown=OVER_FRAMES.
//  ROUND_OVER: Countdown-=1 per frame_tick; at expiry: Blue_score==WIN_SCORE or
//   Red_score==WIN_SCORE -> MATCH_OVER, else -> SPAWN with Countdown=COUNTDOWN_FRAMES.
//  MATCH_OVER: scores/Winner frozen; START press -> SPAWN, scores=0, Winner=00.
//  Crash inputs ignored outside PLAY; keycodes other than START/PAUSE ignored everywhere.
//  Scores saturate at WIN_SCORE (cannot exceed; guarded even if sequencing is violated).
//  START press in SPAWN/PLAY/ROUND_OVER has no effect.
//  frame_tick and state entry same Clk: entry load wins, tick is not counted.
// CONFIGURATION
//  TRON_PAUSE_EN defined: PAUSE press in PLAY -> PAUSE (110); PAUSE press in PAUSE -> PLAY.
//   Crash inputs ignored in PAUSE. Crash and PAUSE press same Clk in PLAY: crash wins.
//   Scores/Winner/Countdown held in PAUSE.
//  TRON_PAUSE_EN undefined: no PAUSE state, PAUSE_KEY ignored, code 110 never driven.
// TESTING
//  Reset_n=0 mid-PLAY with Blue_score=2 -> same-cycle async clear: Game_State=000, scores 0.
//  IDLE, keycode 00->2C held 10 Clk -> one SPAWN entry, Countdown=180; after 180 ticks -> 010.
//  PLAY, Red_crash=1 one Clk -> next Clk Game_State=011, Blue_score=1, Winner=01, Countdown=120.
//  PLAY, Blue_crash=Red_crash=1 same Clk -> Winner=11, scores unchanged, 011; 120 ticks -> 001.
//  Blue wins 3 rounds -> after 3rd ROUND_OVER expiry Game_State=100, Blue_score=3; 2C -> 001, 0-0.
//  TRON_PAUSE_EN: 13 in PLAY -> 110, Red_crash ignored; 13 again -> 010; 13+crash same Clk -> 011.

Source files
------------

// File: rtl/tron_round_ctrl_if.sv
// Bundle between the Tron match sequencer and its neighbours: keyboard/collision inputs,
// plus the game state, countdown, score and winner outputs that the arena and sprites consume.
interface tron_round_ctrl_if;
  logic [7:0] keycode;
  logic       Blue_crash;
  logic       Red_crash;
  logic [2:0] Game_State;
  logic [7:0] Countdown;
  logic [2:0] Blue_score;
  logic [2:0] Red_score;
  logic [1:0] Winner;

  modport master (
    output keycode, Blue_crash, Red_crash,
    input  Game_State, Countdown, Blue_score, Red_score, Winner
  );

  modport slave (
    input  keycode, Blue_crash, Red_crash,
    output Game_State, Countdown, Blue_score, Red_score, Winner
  );
endinterface

// File: rtl/tron_round_ctrl.sv
// Tron match sequencer: IDLE -> SPAWN countdown -> PLAY -> ROUND_OVER -> MATCH_OVER, with scores.
// Optional pause state in PLAY is enabled by defining TRON_PAUSE_EN.
module tron_round_ctrl #(
  parameter int         COUNTDOWN_FRAMES = 180,
  parameter int         OVER_FRAMES      = 120,
  parameter int         WIN_SCORE        = 3,
  parameter logic [7:0] START_KEY        = 8'h2C,
  parameter logic [7:0] PAUSE_KEY        = 8'h13
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_clk,
  tron_round_ctrl_if.slave   bus
);

  localparam logic [2:0] S_IDLE       = 3'b000;
  localparam logic [2:0] S_SPAWN      = 3'b001;
  localparam logic [2:0] S_PLAY       = 3'b010;
  localparam logic [2:0] S_ROUND_OVER = 3'b011;
  localparam logic [2:0] S_MATCH_OVER = 3'b100;
`ifdef TRON_PAUSE_EN
  localparam logic [2:0] S_PAUSE      = 3'b110;
`endif

  localparam logic [7:0] CD_LOAD   = 8'(COUNTDOWN_FRAMES);
  localparam logic [7:0] OVER_LOAD = 8'(OVER_FRAMES);
  localparam logic [2:0] WIN_S     = 3'(WIN_SCORE);

  logic       fsync1_r, fsync2_r, fprev_r;
  logic       frame_tick_s;
  logic [7:0] key_prev_r;
  logic       start_press_s;
  logic       pause_press_s;

  logic [2:0] state_r, state_nxt_s;
  logic [7:0] cd_r, cd_nxt_s;
  logic [2:0] blue_r, blue_nxt_s;
  logic [2:0] red_r, red_nxt_s;
  logic [1:0] winner_r, winner_nxt_s;

  // Scores never pass the match-winning value, even if a crash arrives at an odd time.
  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    if (v < WIN_S) begin
      return v + 3'd1;
    end else begin
      return v;
    end
  endfunction

  // Bring the VGA frame strobe into the Clk domain and keep its previous value for edge detect.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fsync1_r <= 1'b0;
      fsync2_r <= 1'b0;
      fprev_r  <= 1'b0;
    end else begin
      fsync1_r <= frame_clk;
      fsync2_r <= fsync1_r;
      fprev_r  <= fsync2_r;
    end
  end

  assign frame_tick_s = fsync2_r & ~fprev_r;

  // Remember last keycode so a held key counts as a single press.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      key_prev_r <= 8'h00;
    end else begin
      key_prev_r <= bus.keycode;
    end
  end

  assign start_press_s = (bus.keycode == START_KEY) && (key_prev_r != START_KEY);

`ifdef TRON_PAUSE_EN
  assign pause_press_s = (bus.keycode == PAUSE_KEY) && (key_prev_r != PAUSE_KEY);
`else
  logic unused_pause_s;
  assign unused_pause_s = ^PAUSE_KEY;
  assign pause_press_s  = 1'b0;
`endif

  // Next-state, countdown and score decisions for the match sequencer.
  always_comb begin
    state_nxt_s  = state_r;
    cd_nxt_s     = cd_r;
    blue_nxt_s   = blue_r;
    red_nxt_s    = red_r;
    winner_nxt_s = winner_r;
    case (state_r)
      S_IDLE, S_MATCH_OVER: begin
        if (start_press_s) begin
          state_nxt_s  = S_SPAWN;
          cd_nxt_s     = CD_LOAD;
          blue_nxt_s   = 3'd0;
          red_nxt_s    = 3'd0;
          winner_nxt_s = 2'b00;
        end else begin
          cd_nxt_s     = 8'd0;
        end
      end
      S_SPAWN: begin
        if (frame_tick_s) begin
          if (cd_r <= 8'd1) begin
            state_nxt_s = S_PLAY;
            cd_nxt_s    = 8'd0;
          end else begin
            cd_nxt_s    = cd_r - 8'd1;
          end
        end else begin
          cd_nxt_s = cd_r;
        end
      end
      S_PLAY: begin
        // Any crash ends the round; a simultaneous pause request loses to the crash.
        if (bus.Blue_crash && bus.Red_crash) begin
          state_nxt_s  = S_ROUND_OVER;
          cd_nxt_s     = OVER_LOAD;
          winner_nxt_s = 2'b11;
        end else if (bus.Blue_crash) begin
          state_nxt_s  = S_ROUND_OVER;
          cd_nxt_s     = OVER_LOAD;
          red_nxt_s    = sat_inc(red_r);
          winner_nxt_s = 2'b10;
        end else if (bus.Red_crash) begin
          state_nxt_s  = S_ROUND_OVER;
          cd_nxt_s     = OVER_LOAD;
          blue_nxt_s   = sat_inc(blue_r);
          winner_nxt_s = 2'b01;
        end else if (pause_press_s) begin
`ifdef TRON_PAUSE_EN
          state_nxt_s  = S_PAUSE;
`else
          state_nxt_s  = S_PLAY;
`endif
        end else begin
          cd_nxt_s     = 8'd0;
        end
      end
      S_ROUND_OVER: begin
        if (frame_tick_s) begin
          if (cd_r <= 8'd1) begin
            if ((blue_r >= WIN_S) || (red_r >= WIN_S)) begin
              state_nxt_s = S_MATCH_OVER;
              cd_nxt_s    = 8'd0;
            end else begin
              state_nxt_s = S_SPAWN;
              cd_nxt_s    = CD_LOAD;
            end
          end else begin
            cd_nxt_s = cd_r - 8'd1;
          end
        end else begin
          cd_nxt_s = cd_r;
        end
      end
`ifdef TRON_PAUSE_EN
      S_PAUSE: begin
        if (pause_press_s) begin
          state_nxt_s = S_PLAY;
        end else begin
          state_nxt_s = S_PAUSE;
        end
      end
`endif
      default: begin
        state_nxt_s  = S_IDLE;
        cd_nxt_s     = 8'd0;
        blue_nxt_s   = 3'd0;
        red_nxt_s    = 3'd0;
        winner_nxt_s = 2'b00;
      end
    endcase
  end

  // Sequencer state and all visible outputs are held in these registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r  <= S_IDLE;
      cd_r     <= 8'd0;
      blue_r   <= 3'd0;
      red_r    <= 3'd0;
      winner_r <= 2'b00;
    end else begin
      state_r  <= state_nxt_s;
      cd_r     <= cd_nxt_s;
      blue_r   <= blue_nxt_s;
      red_r    <= red_nxt_s;
      winner_r <= winner_nxt_s;
    end
  end

  assign bus.Game_State = state_r;
  assign bus.Countdown  = cd_r;
  assign bus.Blue_score = blue_r;
  assign bus.Red_score  = red_r;
  assign bus.Winner     = winner_r;

endmodule

// File: tb/tb_tron_round_ctrl.sv
// Directed bench for tron_round_ctrl with default parameters (180/120 frames, first to 3).
module tb_tron_round_ctrl;

  logic Clk;
  logic Reset_n;
  logic frame_clk;
  int   n_tests;
  int   n_fail;

  tron_round_ctrl_if bus ();

  tron_round_ctrl dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (frame_clk),
    .bus       (bus.slave)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_clk = 1'b1;
      repeat (4) @(negedge Clk);
      frame_clk = 1'b0;
      repeat (4) @(negedge Clk);
    end
  endtask

  task automatic press(input logic [7:0] key);
    @(negedge Clk);
    bus.keycode = key;
    @(negedge Clk);
    bus.keycode = 8'h00;
  endtask

  task automatic crash(input logic b, input logic r);
    @(negedge Clk);
    bus.Blue_crash = b;
    bus.Red_crash  = r;
    @(negedge Clk);
    bus.Blue_crash = 1'b0;
    bus.Red_crash  = 1'b0;
  endtask

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    Reset_n        = 1'b0;
    frame_clk      = 1'b0;
    bus.keycode    = 8'h00;
    bus.Blue_crash = 1'b0;
    bus.Red_crash  = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_state", {29'd0, bus.Game_State}, 32'd0);
    check("rst_cd", {24'd0, bus.Countdown}, 32'd0);
    check("rst_win", {30'd0, bus.Winner}, 32'd0);
    Reset_n = 1'b1;
    @(negedge Clk);

    // Crash and frames in IDLE do nothing
    crash(1'b0, 1'b1);
    frames(2);
    check("idle_hold", {29'd0, bus.Game_State}, 32'd0);
    check("idle_score", {29'd0, bus.Blue_score}, 32'd0);

    // Held START key: exactly one entry into SPAWN
    @(negedge Clk);
    bus.keycode = 8'h2C;
    @(negedge Clk);
    check("start_state", {29'd0, bus.Game_State}, 32'd1);
    check("start_cd", {24'd0, bus.Countdown}, 32'd180);
    repeat (9) @(negedge Clk);
    check("held_cd", {24'd0, bus.Countdown}, 32'd180);
    bus.keycode = 8'h00;
    frames(179);
    check("spawn_cd1", {24'd0, bus.Countdown}, 32'd1);
    check("spawn_st1", {29'd0, bus.Game_State}, 32'd1);
    press(8'h2C);
    check("spawn_start_ign", {24'd0, bus.Countdown}, 32'd1);
    frames(1);
    check("play_state", {29'd0, bus.Game_State}, 32'd2);
    check("play_cd", {24'd0, bus.Countdown}, 32'd0);
    press(8'h2C);
    check("play_start_ign", {29'd0, bus.Game_State}, 32'd2);

    // Red crashes: blue scores
    @(negedge Clk);
    bus.Red_crash = 1'b1;
    @(negedge Clk);
    bus.Red_crash = 1'b0;
    check("rc_state", {29'd0, bus.Game_State}, 32'd3);
    check("rc_blue", {29'd0, bus.Blue_score}, 32'd1);
    check("rc_win", {30'd0, bus.Winner}, 32'd1);
    check("rc_cd", {24'd0, bus.Countdown}, 32'd120);
    crash(1'b1, 1'b0);
    check("ro_crash_ign", {29'd0, bus.Red_score}, 32'd0);
    frames(119);
    check("ro_cd1", {24'd0, bus.Countdown}, 32'd1);
    frames(1);
    check("ro_to_spawn", {29'd0, bus.Game_State}, 32'd1);
    check("ro_cd_load", {24'd0, bus.Countdown}, 32'd180);

    // Draw round
    frames(180);
    crash(1'b1, 1'b1);
    check("draw_state", {29'd0, bus.Game_State}, 32'd3);
    check("draw_win", {30'd0, bus.Winner}, 32'd3);
    check("draw_blue", {29'd0, bus.Blue_score}, 32'd1);
    check("draw_red", {29'd0, bus.Red_score}, 32'd0);
    frames(120);
    check("draw_spawn", {29'd0, bus.Game_State}, 32'd1);

    // Blue takes rounds 2 and 3 -> match over
    frames(180);
    crash(1'b0, 1'b1);
    frames(120);
    frames(180);
    crash(1'b0, 1'b1);
    check("b3_score", {29'd0, bus.Blue_score}, 32'd3);
    frames(120);
    check("mo_state", {29'd0, bus.Game_State}, 32'd4);
    check("mo_blue", {29'd0, bus.Blue_score}, 32'd3);
    check("mo_cd", {24'd0, bus.Countdown}, 32'd0);
    crash(1'b1, 1'b0);
    check("mo_frozen", {29'd0, bus.Red_score}, 32'd0);
    press(8'h13);
    check("mo_other_key", {29'd0, bus.Game_State}, 32'd4);
    press(8'h2C);
    check("restart_state", {29'd0, bus.Game_State}, 32'd1);
    check("restart_blue", {29'd0, bus.Blue_score}, 32'd0);
    check("restart_win", {30'd0, bus.Winner}, 32'd0);
    check("restart_cd", {24'd0, bus.Countdown}, 32'd180);

    // Second match: red wins a round (pause exercised first when enabled)
    frames(180);
`ifdef TRON_PAUSE_EN
    press(8'h13);
    check("pause_enter", {29'd0, bus.Game_State}, 32'd6);
    crash(1'b0, 1'b1);
    check("pause_crash_ign", {29'd0, bus.Game_State}, 32'd6);
    check("pause_score", {29'd0, bus.Blue_score}, 32'd0);
    press(8'h13);
    check("pause_exit", {29'd0, bus.Game_State}, 32'd2);
    @(negedge Clk);
    bus.keycode    = 8'h13;
    bus.Blue_crash = 1'b1;
    @(negedge Clk);
    bus.keycode    = 8'h00;
    bus.Blue_crash = 1'b0;
`else
    press(8'h13);
    check("pause_ign", {29'd0, bus.Game_State}, 32'd2);
    crash(1'b1, 1'b0);
`endif
    check("bc_state", {29'd0, bus.Game_State}, 32'd3);
    check("bc_red", {29'd0, bus.Red_score}, 32'd1);
    check("bc_win", {30'd0, bus.Winner}, 32'd2);
    frames(120);
    frames(180);
    crash(1'b0, 1'b1);
    frames(120);
    frames(180);
    crash(1'b0, 1'b1);
    frames(120);
    frames(180);
    check("pre_rst_state", {29'd0, bus.Game_State}, 32'd2);
    check("pre_rst_blue", {29'd0, bus.Blue_score}, 32'd2);

    // Asynchronous reset mid-PLAY clears before any clock edge
    #2 Reset_n = 1'b0;
    #1;
    check("arst_state", {29'd0, bus.Game_State}, 32'd0);
    check("arst_blue", {29'd0, bus.Blue_score}, 32'd0);
    check("arst_red", {29'd0, bus.Red_score}, 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
    check("post_rst_idle", {29'd0, bus.Game_State}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
